// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier: one multiplier bit per enabled clock,
// 2N-bit product, start/busy/done handshake with back-to-back restart from DONE.
module shift_add_multiplier #(
  parameter int unsigned C_NUM_BITS = 24
) (
  input  logic                      CK,
  input  logic                      RN,
  input  logic                      E,
  input  logic                      START,
  input  logic [C_NUM_BITS-1:0]     A,
  input  logic [C_NUM_BITS-1:0]     B,
  output logic [2*C_NUM_BITS-1:0]   P,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int unsigned N  = C_NUM_BITS;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCount = CW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [N:0]       acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   p_q, p_d;
  logic [N-1:0]     addend;
  logic [N:0]       sum;

  always_comb begin
    addend = mq_q[0] ? mcand_q : '0;
    // acc[N] is always zero after a shift, so adding the full acc equals adding acc[N-1:0].
    sum    = acc_q + {1'b0, addend};

    state_d = state_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    acc_d   = acc_q;
    count_d = count_q;
    p_d     = p_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (START) begin
          mcand_d = B;
          mq_d    = A;
          acc_d   = '0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Logical right shift of {1'b0, sum, mq}; the carry lands in acc for one shift.
        acc_d   = {1'b0, sum[N:1]};
        mq_d    = {sum[0], mq_q[N-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LastCount) begin
          p_d     = {sum, mq_q[N-1:1]};
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else if (E) begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  assign P    = p_q;
  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDone);

endmodule
